// File: rtl/rst_seq.sv
// rst_seq: reset release sequencer.
// Releases NUM_STAGES active-low block resets one at a time, bit 0 first.
// All outputs stay asserted for HOLD_CYC cycles after RST drops. After that,
// the next stage is released every STAGE_DLY cycles. A software request that
// is seen once every stage is released re-runs the whole sequence. The block
// acknowledges that request with a one-cycle SW_RST_ACK pulse.
//
// Ports:
//   CLK        block clock
//   RST        asynchronous active-high reset (deassertion already synchronized)
//   SW_RST_REQ level request for a full re-sequence
//   STAGE_RDY  per-stage ready/locked indication (only with RST_SEQ_RDY_EN)
//   SW_RST_ACK one-cycle pulse when a request is accepted
//   RST_OUT    active-low stage resets, bit 0 released first
//   SEQ_DONE   high while every stage is released
//
// Optional feature macro: RST_SEQ_RDY_EN
//   When defined, the spacing counter does not leave 0 until the most recently
//   released stage reports ready. In DONE, SEQ_DONE follows the last stage's
//   ready with one cycle of latency.
module rst_seq #(
  parameter int NUM_STAGES = 4,
  parameter int HOLD_CYC   = 8,
  parameter int STAGE_DLY  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SW_RST_REQ,
`ifdef RST_SEQ_RDY_EN
  input  logic [NUM_STAGES-1:0] STAGE_RDY,
`endif
  output logic                  SW_RST_ACK,
  output logic [NUM_STAGES-1:0] RST_OUT,
  output logic                  SEQ_DONE
);

  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [NUM_STAGES-1:0]   rst_out_n;
  logic                    seq_done_n;
  logic                    ack_n;
  logic [NUM_STAGES-1:0]   idx_bit;
  logic                    cnt_en;

  // One-hot mask of the stage that will be released next.
  assign idx_bit = NUM_STAGES'(1) << idx;

`ifdef RST_SEQ_RDY_EN
  // In RELEASE, idx_bit >> 1 selects the stage released most recently. If
  // that stage's reset is still asserted, its ready is not taken into account.
  assign cnt_en = |(STAGE_RDY & RST_OUT & (idx_bit >> 1));
`else
  assign cnt_en = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_HOLD;
      cnt        <= '0;
      idx        <= '0;
      RST_OUT    <= '0;
      SEQ_DONE   <= 1'b0;
      SW_RST_ACK <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      RST_OUT    <= rst_out_n;
      SEQ_DONE   <= seq_done_n;
      SW_RST_ACK <= ack_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    rst_out_n  = RST_OUT;
    seq_done_n = SEQ_DONE;
    ack_n      = 1'b0;

    case (state)
      S_HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          rst_out_n = RST_OUT | NUM_STAGES'(1);
          cnt_n     = '0;
          idx_n     = IDX_W'(1);
          if (NUM_STAGES == 1) begin
            state_n    = S_DONE;
            seq_done_n = 1'b1;
          end else begin
            state_n = S_RELEASE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_RELEASE: begin
        // The counter only waits at 0 for ready. Once it is counting, the
        // stage spacing is fixed.
        if (cnt == '0 && !cnt_en) begin
          cnt_n = '0;
        end else if (cnt == CNT_W'(STAGE_DLY - 1)) begin
          rst_out_n = RST_OUT | idx_bit;
          cnt_n     = '0;
          idx_n     = idx + 1'b1;
          if (idx == IDX_W'(NUM_STAGES - 1)) begin
            state_n    = S_DONE;
            seq_done_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DONE: begin
        if (SW_RST_REQ) begin
          rst_out_n  = '0;
          seq_done_n = 1'b0;
          ack_n      = 1'b1;
          cnt_n      = '0;
          idx_n      = '0;
          state_n    = S_HOLD;
        end
`ifdef RST_SEQ_RDY_EN
        else begin
          seq_done_n = STAGE_RDY[NUM_STAGES-1];
        end
`endif
      end

      default: begin
        state_n = S_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: self-checking bench for rst_seq with the default parameters.
// A behavioural model tracks the number of clock edges since the last reset
// event (RST or an accepted SW request). From that count it derives which
// stage resets must be released. Directed literal checks pin the documented
// timeline. A randomized phase then drives SW requests and asynchronous RST
// pulses against the model.
module tb_rst_seq;

  localparam int N      = 4;
  localparam int H      = 8;
  localparam int D      = 4;
  localparam int T_DONE = H + (N - 1) * D;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         SW_RST_REQ = 1'b0;
  logic         SW_RST_ACK;
  logic [N-1:0] RST_OUT;
  logic         SEQ_DONE;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  rst_seq #(
    .NUM_STAGES (N),
    .HOLD_CYC   (H),
    .STAGE_DLY  (D),
    .CNT_W      (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
`ifdef RST_SEQ_RDY_EN
    .STAGE_RDY  ('1),
`endif
    .SW_RST_ACK (SW_RST_ACK),
    .RST_OUT    (RST_OUT),
    .SEQ_DONE   (SEQ_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model. e counts the edges since the last reset event.
  // The sequence is complete once e reaches T_DONE.
  int e     = 0;
  bit ack_m = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      e     = 0;
      ack_m = 1'b0;
    end else if (e >= T_DONE && SW_RST_REQ) begin
      e     = 0;
      ack_m = 1'b1;
    end else begin
      if (e < 1000) e = e + 1;
      ack_m = 1'b0;
    end
  end

  always @(negedge CLK) begin
    logic [N-1:0] exp_out;
    if (run) begin
      for (int k = 0; k < N; k++) exp_out[k] = (e >= H + k * D);
      chk("model_rst_out", 32'(RST_OUT), 32'(exp_out));
      chk("model_seq_done", 32'(SEQ_DONE), 32'(e >= T_DONE));
      chk("model_ack", 32'(SW_RST_ACK), 32'(ack_m));
    end
  end

  // Wait n rising edges, then step 1 time unit past the last one.
  task automatic go(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sw_pulse();
    #1 SW_RST_REQ = 1'b1;
    go(1);
    chk("sw_ack", 32'(SW_RST_ACK), 32'd1);
    chk("sw_out_clr", 32'(RST_OUT), 32'h0);
    #1 SW_RST_REQ = 1'b0;
  endtask

  initial begin
    #1 run = 1'b1;
    go(5);
    chk("por_out", 32'(RST_OUT), 32'h0);
    chk("por_done", 32'(SEQ_DONE), 32'd0);
    chk("por_ack", 32'(SW_RST_ACK), 32'd0);
    #1 RST = 1'b0;

    // Power-up timeline: stages released at edges 8, 12, 16 and 20.
    go(7);  chk("pu_e7", 32'(RST_OUT), 32'h0);
    go(1);  chk("pu_e8", 32'(RST_OUT), 32'h1);
    go(3);  chk("pu_e11", 32'(RST_OUT), 32'h1);
    go(1);  chk("pu_e12", 32'(RST_OUT), 32'h3);
    go(4);  chk("pu_e16", 32'(RST_OUT), 32'h7);
            chk("pu_e16_done", 32'(SEQ_DONE), 32'd0);
    go(3);  chk("pu_e19", 32'(RST_OUT), 32'h7);
    go(1);  chk("pu_e20", 32'(RST_OUT), 32'hf);
            chk("pu_e20_done", 32'(SEQ_DONE), 32'd1);

    // SW reset accepted in DONE, then the full sequence repeats.
    sw_pulse();
    chk("sw_done_clr", 32'(SEQ_DONE), 32'd0);
    go(1);  chk("sw_ack_once", 32'(SW_RST_ACK), 32'd0);
    go(6);  chk("sw_e7", 32'(RST_OUT), 32'h0);
    go(1);  chk("sw_e8", 32'(RST_OUT), 32'h1);
    go(12); chk("sw_e20", 32'(RST_OUT), 32'hf);
            chk("sw_e20_done", 32'(SEQ_DONE), 32'd1);

    // A request during RELEASE is ignored and is not queued.
    sw_pulse();
    go(10);
    #1 SW_RST_REQ = 1'b1;
    go(1);  chk("rel_req_noack1", 32'(SW_RST_ACK), 32'd0);
    go(1);  chk("rel_req_noack2", 32'(SW_RST_ACK), 32'd0);
            chk("rel_req_e12", 32'(RST_OUT), 32'h3);
    #1 SW_RST_REQ = 1'b0;
    go(8);  chk("rel_req_e20", 32'(RST_OUT), 32'hf);
    go(1);  chk("rel_req_not_queued", 32'(SW_RST_ACK), 32'd0);

    // Asynchronous RST in the middle of the sequence.
    sw_pulse();
    go(14);
    #2 RST = 1'b1;
    #1;
    chk("async_out", 32'(RST_OUT), 32'h0);
    chk("async_done", 32'(SEQ_DONE), 32'd0);
    go(2);
    #1 RST = 1'b0;
    go(7);  chk("async_e7", 32'(RST_OUT), 32'h0);
    go(1);  chk("async_e8", 32'(RST_OUT), 32'h1);
    go(12); chk("async_e20", 32'(RST_OUT), 32'hf);

    // A request held high re-triggers the reset each time DONE is reached.
    #1 SW_RST_REQ = 1'b1;
    go(1);  chk("held_ack1", 32'(SW_RST_ACK), 32'd1);
    go(20); chk("held_e20", 32'(RST_OUT), 32'hf);
            chk("held_e20_ack", 32'(SW_RST_ACK), 32'd0);
    go(1);  chk("held_ack2", 32'(SW_RST_ACK), 32'd1);
            chk("held_out_clr", 32'(RST_OUT), 32'h0);
    go(20);
    #1 SW_RST_REQ = 1'b0;
    go(1);  chk("held_drop_noack", 32'(SW_RST_ACK), 32'd0);
            chk("held_drop_out", 32'(RST_OUT), 32'hf);

    // Randomized phase: toggling requests and occasional async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK);
      #2;
      if ($urandom_range(0, 199) == 0) begin
        #1 RST = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #2 RST = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        SW_RST_REQ = ~SW_RST_REQ;
      end
    end

    SW_RST_REQ = 1'b0;
    go(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
